// File: rtl/segre_itlb_ptw.sv
// segre_itlb_ptw: single-level page-table walker that refills the instruction TLB on a miss
module segre_itlb_ptw #(
    parameter int                   WORD_SIZE      = 32,
    parameter int                   VIRT_PAGE_BITS = 20,
    parameter int                   PHYS_PAGE_BITS = 8,
    parameter logic [WORD_SIZE-1:0] PT_BASE        = 32'h0000_4000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      miss_i,
    input  logic [WORD_SIZE-1:0]      miss_vaddr_i,
    input  logic                      flush_i,
    output logic                      mem_req_o,
    output logic [WORD_SIZE-1:0]      mem_addr_o,
    input  logic                      mem_ready_i,
    input  logic [WORD_SIZE-1:0]      mem_rdata_i,
    output logic                      tlb_we_o,
    output logic [WORD_SIZE-1:0]      tlb_vaddr_o,
    output logic [PHYS_PAGE_BITS-1:0] tlb_ppage_o,
    output logic                      busy_o,
    output logic                      fault_o,
    output logic [15:0]               walk_cnt_o
);
    typedef enum logic [2:0] {IDLE, REQ, CHECK, FILL, FAULT} state_t;

    state_t                    state, state_nx;
    logic [VIRT_PAGE_BITS-1:0] vpn;
    logic [PHYS_PAGE_BITS-1:0] ppn;
    logic                      valid;
    logic                      abort_pending;
    logic [WORD_SIZE-1:0]      mem_addr;
    logic [15:0]               walk_cnt;
    logic                      start;
    logic                      accept;
    logic                      unused_bits;

    assign start       = state == IDLE && miss_i && !flush_i;
    assign accept      = state == REQ && mem_ready_i && !abort_pending && !flush_i;
    assign unused_bits = ^{mem_rdata_i[WORD_SIZE-1:PHYS_PAGE_BITS+12], mem_rdata_i[11:1], miss_vaddr_i[11:0]};

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and state-decoded outputs; an issued read is always allowed to complete
    always_comb begin
        state_nx    = state;
        mem_req_o   = 1'b0;
        tlb_we_o    = 1'b0;
        busy_o      = 1'b0;
        fault_o     = 1'b0;
        mem_addr_o  = mem_addr;
        tlb_vaddr_o = {vpn, 12'b0};
        tlb_ppage_o = ppn;
        walk_cnt_o  = walk_cnt;
        case (state)
            IDLE:    state_nx = start ? REQ : IDLE;
            REQ: begin
                mem_req_o = 1'b1;
                busy_o    = 1'b1;
                state_nx  = !mem_ready_i ? REQ : (accept ? CHECK : IDLE);
            end
            CHECK: begin
                busy_o   = 1'b1;
                state_nx = flush_i ? IDLE : (valid ? FILL : FAULT);
            end
            FILL: begin
                tlb_we_o = 1'b1;
                busy_o   = 1'b1;
                state_nx = IDLE;
            end
            FAULT: begin
                fault_o  = 1'b1;
                state_nx = flush_i ? IDLE : FAULT;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Walk datapath: latch the page on start, the PTE on an unaborted response, count fills
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vpn           <= '0;
            ppn           <= '0;
            valid         <= 1'b0;
            abort_pending <= 1'b0;
            mem_addr      <= '0;
            walk_cnt      <= '0;
        end else begin
            if (start) begin
                vpn      <= miss_vaddr_i[WORD_SIZE-1:12];
                mem_addr <= PT_BASE + WORD_SIZE'({miss_vaddr_i[WORD_SIZE-1:12], 2'b00});
            end
            if (state == REQ) abort_pending <= mem_ready_i ? 1'b0 : (abort_pending | flush_i);
            if (accept) begin
                valid <= mem_rdata_i[0];
                ppn   <= mem_rdata_i[PHYS_PAGE_BITS+11:12];
            end
            if (state == FILL && walk_cnt != 16'hFFFF) walk_cnt <= walk_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_segre_itlb_ptw.sv
// tb_segre_itlb_ptw: vector table, directed corner sequences and randomized walks against a page-table model
module tb_segre_itlb_ptw;
    logic        clk = 1'b0;
    logic        rst, miss, flush, mem_ready;
    logic [31:0] vaddr, rdata;
    logic        req, we, busy, fault, req2, we2, busy2, fault2;
    logic [31:0] addr, tvaddr, addr2, tvaddr2;
    logic [7:0]  ppage, ppage2;
    logic [15:0] cnt, cnt2;
    int          checks = 0;
    int          fails = 0;
    int          model_cnt = 0;

    typedef struct {
        logic [31:0] va;
        logic [31:0] pte;
        int          waits;
        bit          flush_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_addr2;
        bit          exp_fill;
        logic [7:0]  exp_ppage;
    } vec_t;

    vec_t tbl[6];

    segre_itlb_ptw dut (
        .clk_i(clk), .rst_i(rst), .miss_i(miss), .miss_vaddr_i(vaddr), .flush_i(flush),
        .mem_req_o(req), .mem_addr_o(addr), .mem_ready_i(mem_ready), .mem_rdata_i(rdata),
        .tlb_we_o(we), .tlb_vaddr_o(tvaddr), .tlb_ppage_o(ppage), .busy_o(busy),
        .fault_o(fault), .walk_cnt_o(cnt)
    );

    segre_itlb_ptw #(.PT_BASE(32'hFFFF_FFF0)) dut2 (
        .clk_i(clk), .rst_i(rst), .miss_i(miss), .miss_vaddr_i(vaddr), .flush_i(flush),
        .mem_req_o(req2), .mem_addr_o(addr2), .mem_ready_i(mem_ready), .mem_rdata_i(rdata),
        .tlb_we_o(we2), .tlb_vaddr_o(tvaddr2), .tlb_ppage_o(ppage2), .busy_o(busy2),
        .fault_o(fault2), .walk_cnt_o(cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sat_inc(input int c);
        return (c >= 65535) ? 16'hFFFF : 16'(c + 1);
    endfunction

    // Lockstep walk: starts and ends on a negedge with the walker idle
    task automatic run_walk(input vec_t v);
        miss = 1'b1; vaddr = v.va; mem_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        miss = 1'b0; vaddr = $urandom;
        chk("req_start", {31'b0, req}, 32'd1);
        chk("req_addr", addr, v.exp_addr);
        chk("req_addr_wrap", addr2, v.exp_addr2);
        chk("busy_req", {31'b0, busy}, 32'd1);
        for (int i = 0; i < v.waits; i++) begin
            flush = v.flush_req && i == 0;
            miss  = 1'($urandom);
            @(negedge clk);
            flush = 1'b0;
            chk("req_held", {31'b0, req}, 32'd1);
            chk("addr_held", addr, v.exp_addr);
            chk("busy_wait", {31'b0, busy}, 32'd1);
        end
        miss = 1'b0; mem_ready = 1'b1; rdata = v.pte;
        @(negedge clk);
        mem_ready = 1'b0; rdata = $urandom;
        if (v.flush_req) begin
            chk("abort_idle_busy", {31'b0, busy}, 32'd0);
            chk("abort_idle_req", {31'b0, req}, 32'd0);
            @(negedge clk);
            chk("abort_no_we", {31'b0, we}, 32'd0);
            chk("abort_cnt", {16'b0, cnt}, model_cnt);
            return;
        end
        chk("check_busy", {31'b0, busy}, 32'd1);
        chk("check_no_we", {31'b0, we}, 32'd0);
        @(negedge clk);
        if (v.exp_fill) begin
            chk("fill_we", {31'b0, we}, 32'd1);
            chk("fill_vaddr", tvaddr, v.va & 32'hFFFF_F000);
            chk("fill_ppage", {24'b0, ppage}, {24'b0, v.exp_ppage});
            chk("fill_cnt_before", {16'b0, cnt}, model_cnt);
            model_cnt = sat_inc(model_cnt);
            @(negedge clk);
            chk("post_fill_we", {31'b0, we}, 32'd0);
            chk("post_fill_busy", {31'b0, busy}, 32'd0);
            chk("post_fill_cnt", {16'b0, cnt}, model_cnt);
        end else begin
            for (int i = 0; i < 10; i++) begin
                chk("fault_held", {31'b0, fault}, 32'd1);
                chk("fault_busy", {31'b0, busy}, 32'd0);
                chk("fault_no_we", {31'b0, we}, 32'd0);
                @(negedge clk);
            end
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            chk("fault_cleared", {31'b0, fault}, 32'd0);
            chk("fault_cnt", {16'b0, cnt}, model_cnt);
        end
    endtask

    initial begin
        vec_t rv;
        tbl[0] = '{32'h0000_3ABC, 32'h0000_9001, 0, 1'b0, 32'h0000_400C, 32'hFFFF_FFFC, 1'b1, 8'h09};
        tbl[1] = '{32'h0001_2345, 32'h0005_5001, 4, 1'b0, 32'h0000_4048, 32'h0000_0038, 1'b1, 8'h55};
        tbl[2] = '{32'h0000_3ABC, 32'h0000_9000, 0, 1'b0, 32'h0000_400C, 32'hFFFF_FFFC, 1'b0, 8'h00};
        tbl[3] = '{32'h0000_7000, 32'h0000_A001, 2, 1'b1, 32'h0000_401C, 32'h0000_000C, 1'b0, 8'h00};
        tbl[4] = '{32'h0000_5000, 32'h0000_1001, 1, 1'b0, 32'h0000_4014, 32'h0000_0004, 1'b1, 8'h01};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FF01, 0, 1'b0, 32'h0040_3FFC, 32'h003F_FFEC, 1'b1, 8'hFF};

        rst = 1'b1; miss = 1'b0; flush = 1'b0; mem_ready = 1'b0; vaddr = '0; rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_vaddr", tvaddr, 32'd0);
        chk("rst_cnt", {16'b0, cnt}, 32'd0);

        miss = 1'b1; flush = 1'b1; vaddr = 32'h0000_1000;
        @(negedge clk);
        miss = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", {31'b0, busy}, 32'd0);
        chk("idle_flush_req", {31'b0, req}, 32'd0);

        for (int i = 0; i < 6; i++) run_walk(tbl[i]);

        miss = 1'b1; vaddr = 32'h0000_8000; mem_ready = 1'b1; rdata = 32'h0000_3001;
        @(negedge clk);
        miss = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0; flush = 1'b1;
        chk("check_state_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        chk("check_flush_we", {31'b0, we}, 32'd0);
        chk("check_flush_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("check_flush_we2", {31'b0, we}, 32'd0);
        chk("check_flush_cnt", {16'b0, cnt}, model_cnt);

        miss = 1'b1; vaddr = 32'h0000_9000; mem_ready = 1'b1; rdata = 32'h0000_4001;
        @(negedge clk);
        miss = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("fill_flush_we", {31'b0, we}, 32'd1);
        flush = 1'b1;
        model_cnt = sat_inc(model_cnt);
        @(negedge clk);
        flush = 1'b0;
        chk("fill_flush_busy", {31'b0, busy}, 32'd0);
        chk("fill_flush_cnt", {16'b0, cnt}, model_cnt);

        for (int n = 0; n < 40; n++) begin
            rv.va        = $urandom;
            rv.pte       = $urandom;
            rv.waits     = $urandom_range(0, 3);
            rv.flush_req = rv.waits > 0 && $urandom_range(0, 3) == 0;
            rv.exp_addr  = 32'h0000_4000 + (rv.va >> 12) * 4;
            rv.exp_addr2 = 32'hFFFF_FFF0 + (rv.va >> 12) * 4;
            rv.exp_fill  = !rv.flush_req && rv.pte[0];
            rv.exp_ppage = 8'((rv.pte >> 12) & 32'hFF);
            run_walk(rv);
        end

        // Most of the count is preloaded so the saturation edge is reached in a short run
        dut.walk_cnt = 16'hFFFD;
        model_cnt = 65533;
        for (int n = 0; n < 3; n++) run_walk(tbl[0]);
        chk("sat_cnt", {16'b0, cnt}, 32'h0000_FFFF);

        miss = 1'b1; vaddr = 32'h0000_3ABC; mem_ready = 1'b0;
        @(negedge clk);
        miss = 1'b0;
        chk("pre_rst_req", {31'b0, req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        chk("midrst_req", {31'b0, req}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_we", {31'b0, we}, 32'd0);
        chk("midrst_fault", {31'b0, fault}, 32'd0);
        chk("midrst_addr", addr, 32'd0);
        chk("midrst_vaddr", tvaddr, 32'd0);
        chk("midrst_ppage", {24'b0, ppage}, 32'd0);
        chk("midrst_cnt", {16'b0, cnt}, 32'd0);
        run_walk(tbl[4]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
